// File: rtl/crc_seq_ctrl_pkg.sv
`default_nettype none
// ==========================================================================
// Package  : crc_seq_pkg
// Brief    : Shared defaults, counter widths and FSM state type for crc_seq_ctrl.
// Revision : 1.0
// ==========================================================================
package crc_seq_pkg;

   localparam int CRC_SEQ_DATA_WIDTH  = 8;
   localparam int CRC_SEQ_CRC_WIDTH   = 8;
   localparam int CRC_SEQ_TIMEOUT_CYC = 32;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CRC_SEQ_BIT_CNT_W = cnt_w(CRC_SEQ_DATA_WIDTH);
   localparam int CRC_SEQ_CAP_CNT_W = cnt_w(CRC_SEQ_CRC_WIDTH);
   localparam int CRC_SEQ_TO_CNT_W  = cnt_w(CRC_SEQ_TIMEOUT_CYC);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INIT       = 3'd1,
      ST_ARM        = 3'd2,
      ST_SHIFT      = 3'd3,
      ST_WAIT_VALID = 3'd4,
      ST_CAPTURE    = 3'd5,
      ST_DONE       = 3'd6,
      ST_ABORT      = 3'd7
   } crc_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/crc_seq_ctrl_if.sv
`default_nettype none
// ==========================================================================
// Interface : crc_seq_ctrl_if
// Brief     : Frame input, engine pins and result handshake of crc_seq_ctrl.
// Revision  : 1.0
// ==========================================================================
interface crc_seq_ctrl_if
   import crc_seq_pkg::*;
#(
   parameter int DATA_WIDTH = CRC_SEQ_DATA_WIDTH,
   parameter int CRC_WIDTH  = CRC_SEQ_CRC_WIDTH
);
   logic [DATA_WIDTH-1:0] IN_DATA;
   logic                  IN_VALID;
   logic                  IN_LAST;
   logic                  IN_READY;
   logic                  ENG_RST;
   logic                  ENG_DATA;
   logic                  ENG_ACTIVE;
   logic                  ENG_CRC;
   logic                  ENG_VALID;
   logic [CRC_WIDTH-1:0]  RES_CRC;
   logic                  RES_VALID;
   logic                  RES_ERR;
   logic                  RES_READY;
   logic                  BUSY;

   modport slave (
      input  IN_DATA, IN_VALID, IN_LAST, ENG_CRC, ENG_VALID, RES_READY,
      output IN_READY, ENG_RST, ENG_DATA, ENG_ACTIVE, RES_CRC, RES_VALID, RES_ERR, BUSY
   );

   modport master (
      output IN_DATA, IN_VALID, IN_LAST, ENG_CRC, ENG_VALID, RES_READY,
      input  IN_READY, ENG_RST, ENG_DATA, ENG_ACTIVE, RES_CRC, RES_VALID, RES_ERR, BUSY
   );
endinterface
`default_nettype wire

// File: rtl/crc_seq_ctrl_deser.sv
`default_nettype none
// ==========================================================================
// Module   : crc_seq_deser
// Brief    : LSB-first serial-to-parallel capture of the engine CRC result.
// Revision : 1.0
// ==========================================================================
module crc_seq_deser
   import crc_seq_pkg::*;
#(
   parameter int CRC_WIDTH = CRC_SEQ_CRC_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic                 bit_in,
   output logic [CRC_WIDTH-1:0] data,
   output logic                 done
);
   localparam int                CNT_W    = cnt_w(CRC_WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CRC_WIDTH - 1);

   logic [CRC_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   assign done = en && (cnt_q == CNT_LAST);
   assign data = data_q;

   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (en) begin
         data_d[cnt_q] = bit_in;
         cnt_d         = done ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/crc_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : crc_seq_ctrl
// Brief    : Sequencer for the serial CRC engine: re-init, LSB-first serialise,
//            wait for Valid, deserialise and present the result.
// Options  : CRC_SEQ_TIMEOUT_EN bounds WAIT_VALID to TIMEOUT_CYC cycles.
// Revision : 1.0
// ==========================================================================
module crc_seq_ctrl
   import crc_seq_pkg::*;
#(
   parameter int DATA_WIDTH  = CRC_SEQ_DATA_WIDTH,
   parameter int CRC_WIDTH   = CRC_SEQ_CRC_WIDTH,
   parameter int TIMEOUT_CYC = CRC_SEQ_TIMEOUT_CYC
) (
   input  logic          CLK,
   input  logic          RST,
   crc_seq_ctrl_if.slave bus
);
   localparam int               BIT_W    = cnt_w(DATA_WIDTH);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   crc_seq_state_e        state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic                  last_q, last_d;
   logic                  in_ready_q, in_ready_d;
   logic                  eng_rst_q, eng_rst_d;
   logic                  eng_data_q, eng_data_d;
   logic                  eng_active_q, eng_active_d;
   logic                  res_valid_q, res_valid_d;
   logic                  res_err_q, res_err_d;
   logic                  busy_q, busy_d;

   logic                  in_hs;
   logic                  cap_en, cap_clr, cap_done;
   logic [CRC_WIDTH-1:0]  cap_data;
   logic                  timeout_hit;

   assign in_hs = bus.IN_VALID & in_ready_q;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
      $error("crc_seq_ctrl: TIMEOUT_CYC must be at least 1");
   end

`ifdef CRC_SEQ_TIMEOUT_EN
   localparam int              TO_W    = cnt_w(TIMEOUT_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   // Counts completed WAIT_VALID cycles; the last one without Valid aborts.
   assign to_cnt_d    = (state_q == ST_WAIT_VALID) ? to_cnt_q + TO_W'(1) : '0;
   assign timeout_hit = (state_q == ST_WAIT_VALID) && (to_cnt_q == TO_LAST);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) to_cnt_q <= '0;
      else      to_cnt_q <= to_cnt_d;
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      last_d    = last_q;
      cap_en    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (in_hs) begin
               shreg_d   = bus.IN_DATA;
               last_d    = bus.IN_LAST;
               bit_cnt_d = '0;
               state_d   = ST_INIT;
            end
         end
         ST_INIT: state_d = ST_ARM;
         ST_ARM:  state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (bit_cnt_q != BIT_LAST) begin
               shreg_d   = shreg_q >> 1;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end else if (last_q) begin
               state_d = ST_WAIT_VALID;
            end else if (in_hs) begin
               shreg_d   = bus.IN_DATA;
               last_d    = bus.IN_LAST;
               bit_cnt_d = '0;
            end else begin
               state_d = ST_ABORT;
            end
         end
         ST_WAIT_VALID: begin
            if (bus.ENG_VALID) begin
               cap_en  = 1'b1;
               state_d = cap_done ? ST_DONE : ST_CAPTURE;
            end else if (timeout_hit) begin
               state_d = ST_ABORT;
            end
         end
         ST_CAPTURE: begin
            cap_en = 1'b1;
            if (cap_done) state_d = ST_DONE;
         end
         ST_DONE, ST_ABORT: begin
            if (bus.RES_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered images of the next state so they line up with it.
      cap_clr      = (state_d == ST_INIT) || (state_d == ST_ABORT);
      in_ready_d   = (state_d == ST_IDLE) ||
                     ((state_d == ST_SHIFT) && (bit_cnt_d == BIT_LAST) && !last_d);
      eng_rst_d    = (state_d != ST_INIT);
      eng_active_d = (state_d == ST_SHIFT);
      eng_data_d   = (state_d == ST_SHIFT) ? shreg_d[0] : 1'b0;
      res_valid_d  = (state_d == ST_DONE) || (state_d == ST_ABORT);
      res_err_d    = (state_d == ST_ABORT);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         bit_cnt_q    <= '0;
         last_q       <= 1'b0;
         in_ready_q   <= 1'b0;
         eng_rst_q    <= 1'b0;
         eng_data_q   <= 1'b0;
         eng_active_q <= 1'b0;
         res_valid_q  <= 1'b0;
         res_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bit_cnt_q    <= bit_cnt_d;
         last_q       <= last_d;
         in_ready_q   <= in_ready_d;
         eng_rst_q    <= eng_rst_d;
         eng_data_q   <= eng_data_d;
         eng_active_q <= eng_active_d;
         res_valid_q  <= res_valid_d;
         res_err_q    <= res_err_d;
         busy_q       <= busy_d;
      end
   end

   crc_seq_deser #(
      .CRC_WIDTH (CRC_WIDTH)
   ) u_deser (
      .clk    (CLK),
      .rst_n  (RST),
      .clr    (cap_clr),
      .en     (cap_en),
      .bit_in (bus.ENG_CRC),
      .data   (cap_data),
      .done   (cap_done)
   );

   assign bus.IN_READY   = in_ready_q;
   assign bus.ENG_RST    = eng_rst_q;
   assign bus.ENG_DATA   = eng_data_q;
   assign bus.ENG_ACTIVE = eng_active_q;
   assign bus.RES_CRC    = cap_data;
   assign bus.RES_VALID  = res_valid_q;
   assign bus.RES_ERR    = res_err_q;
   assign bus.BUSY       = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_crc_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// Module   : tb_crc_seq_ctrl
// Brief    : Bench for crc_seq_ctrl with a stub serial CRC engine.
// Revision : 1.0
// ==========================================================================
module tb_crc_seq_ctrl;

   typedef struct {
      int          n;
      logic [31:0] words;
      int          drop_at;
      logic [7:0]  crc;
      int          hold;
      logic        exp_err;
      logic [7:0]  exp_crc;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   // stub engine controls and observations
   logic [7:0]  stub_crc = 8'h00;
   int          stub_lat = 1;
   bit          stub_never = 1'b0;
   bit          eng_seen = 1'b0;
   int          eng_wait = 0;
   int          eng_bit = 0;
   bit          prev_active = 1'b0;
   logic [31:0] act_stream = '0;
   int          act_cnt = 0, act_runs = 0;
   int          rst_low_cnt = 0, rst_low_cyc = -1;
   int          first_active_cyc = -1, last_active_cyc = -1, first_valid_cyc = -1;

   crc_seq_ctrl_if #(.DATA_WIDTH(8), .CRC_WIDTH(8)) bus ();

   crc_seq_ctrl #(
      .DATA_WIDTH  (8),
      .CRC_WIDTH   (8),
      .TIMEOUT_CYC (32)
   ) dut (
      .CLK (clk),
      .RST (rst_n),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst_n || !bus.ENG_RST) begin
         eng_seen        = 1'b0;
         eng_wait        = 0;
         eng_bit         = 0;
         bus.ENG_VALID   = 1'b0;
         bus.ENG_CRC     = 1'b0;
         first_valid_cyc = -1;
         if (rst_n) begin
            rst_low_cnt++;
            rst_low_cyc = cyc;
         end
      end else if (bus.ENG_ACTIVE) begin
         if (act_cnt < 32) act_stream[act_cnt] = bus.ENG_DATA;
         if (!prev_active) begin
            act_runs++;
            if (first_active_cyc < 0) first_active_cyc = cyc;
         end
         act_cnt++;
         last_active_cyc = cyc;
         eng_seen      = 1'b1;
         eng_wait      = 0;
         eng_bit       = 0;
         bus.ENG_VALID = 1'b0;
      end else if (eng_seen && !stub_never) begin
         if (eng_wait < stub_lat) begin
            eng_wait++;
            bus.ENG_VALID = 1'b0;
         end else if (eng_bit < 8) begin
            bus.ENG_VALID = 1'b1;
            bus.ENG_CRC   = stub_crc[eng_bit];
            if (eng_bit == 0) first_valid_cyc = cyc;
            eng_bit++;
         end else begin
            bus.ENG_VALID = 1'b0;
            eng_seen      = 1'b0;
         end
      end
      prev_active = bus.ENG_ACTIVE;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_metrics();
      act_stream       = '0;
      act_cnt          = 0;
      act_runs         = 0;
      rst_low_cnt      = 0;
      rst_low_cyc      = -1;
      first_active_cyc = -1;
      last_active_cyc  = -1;
      first_valid_cyc  = -1;
   endtask

   // Called at a negedge; returns at the negedge following the handshake.
   task automatic send_word(input logic [7:0] d, input logic last, output bit ok);
      int t = 0;
      bus.IN_DATA  = d;
      bus.IN_LAST  = last;
      bus.IN_VALID = 1'b1;
      while (!bus.IN_READY && t < 200) begin
         @(negedge clk);
         t++;
      end
      ok = bus.IN_READY;
      @(negedge clk);
      bus.IN_VALID = 1'b0;
   endtask

   task automatic wait_result(output bit got, output int rise_cyc);
      int t = 0;
      while (!bus.RES_VALID && t < 400) begin
         @(negedge clk);
         t++;
      end
      got      = bus.RES_VALID;
      rise_cyc = cyc;
      if (!got) check("res_valid_wait", 32'd0, 32'd1);
   endtask

   // Reference: an underrun aborts with a zero result, otherwise the stub CRC comes back.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      r.exp_err = (v.drop_at >= 0);
      r.exp_crc = r.exp_err ? 8'h00 : v.crc;
      return r;
   endfunction

   task automatic run_vec(input vec_t v);
      bit          ok, got;
      int          rise, nact, nw;
      logic [31:0] exp_s;
      clear_metrics();
      stub_crc = v.crc;
      for (int i = 0; i < v.n; i++) begin
         if (i == v.drop_at) break;
         send_word(v.words[8*i +: 8], (i == v.n - 1), ok);
         if (!ok) check("in_ready_wait", 32'd0, 32'd1);
         if (i == 0) check("init_rst_busy", {bus.ENG_RST, bus.BUSY}, 32'b01);
      end
      wait_result(got, rise);
      check("res_err", bus.RES_ERR, v.exp_err);
      check("res_crc", bus.RES_CRC, v.exp_crc);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         check("res_hold", {bus.RES_VALID, bus.RES_ERR, bus.RES_CRC}, {1'b1, v.exp_err, v.exp_crc});
      end
      bus.RES_READY = 1'b1;
      @(negedge clk);
      bus.RES_READY = 1'b0;
      check("res_release", {bus.RES_VALID, bus.BUSY}, 32'b00);

      nw    = v.exp_err ? v.drop_at : v.n;
      nact  = 8 * nw;
      exp_s = (nact >= 32) ? v.words : (v.words & ((32'd1 << nact) - 32'd1));
      check("active_cycles", act_cnt, nact);
      check("active_runs", act_runs, 1);
      check("bit_stream", act_stream, exp_s);
      check("eng_rst_pulses", rst_low_cnt, 1);
      check("rst_to_active", first_active_cyc - rst_low_cyc, 2);
      if (!v.exp_err) check("valid_to_result", rise - first_valid_cyc, 8);
   endtask

   vec_t tbl [6];

   initial begin
      bit   ok, got;
      int   rise;
      vec_t v;

      tbl[0] = '{n:1, words:32'h000000A5, drop_at:-1, crc:8'h3C, hold:3, exp_err:1'b0, exp_crc:8'h3C};
      tbl[1] = '{n:2, words:32'h00003412, drop_at:-1, crc:8'h5A, hold:1, exp_err:1'b0, exp_crc:8'h5A};
      tbl[2] = '{n:2, words:32'h00003412, drop_at:1,  crc:8'h77, hold:2, exp_err:1'b1, exp_crc:8'h00};
      tbl[3] = '{n:1, words:32'h000000FF, drop_at:-1, crc:8'hC3, hold:0, exp_err:1'b0, exp_crc:8'hC3};
      tbl[4] = '{n:3, words:32'h00FE8001, drop_at:-1, crc:8'h81, hold:1, exp_err:1'b0, exp_crc:8'h81};
      tbl[5] = '{n:4, words:32'hDEADBEEF, drop_at:2,  crc:8'hFF, hold:1, exp_err:1'b1, exp_crc:8'h00};

      rst_n         = 1'b0;
      bus.IN_DATA   = '0;
      bus.IN_VALID  = 1'b0;
      bus.IN_LAST   = 1'b0;
      bus.RES_READY = 1'b0;
      bus.ENG_VALID = 1'b0;
      bus.ENG_CRC   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs",
            {bus.IN_READY, bus.ENG_RST, bus.ENG_DATA, bus.ENG_ACTIVE,
             bus.RES_VALID, bus.RES_ERR, bus.BUSY, bus.RES_CRC}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", {bus.IN_READY, bus.ENG_RST, bus.BUSY}, 32'b110);

      for (int i = 0; i < 6; i++) begin
         stub_lat = 1 + (i % 3);
         run_vec(tbl[i]);
      end

      // Reset in the middle of the first word's SHIFT, then a clean frame.
      clear_metrics();
      send_word(8'h11, 1'b0, ok);
      repeat (5) @(negedge clk);
      check("mid_shift", {bus.ENG_ACTIVE, bus.BUSY}, 32'b11);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.IN_READY, bus.ENG_RST, bus.ENG_DATA, bus.ENG_ACTIVE,
             bus.RES_VALID, bus.RES_ERR, bus.BUSY, bus.RES_CRC}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      v = model('{n:1, words:32'h000000FF, drop_at:-1, crc:8'h96, hold:1, exp_err:1'b0, exp_crc:8'h00});
      run_vec(v);

      for (int r = 0; r < 24; r++) begin
         v.n       = int'($urandom_range(1, 4));
         v.words   = $urandom;
         v.crc     = 8'($urandom);
         v.hold    = int'($urandom_range(0, 3));
         v.drop_at = -1;
         if (v.n > 1 && $urandom_range(0, 3) == 0) v.drop_at = int'($urandom_range(1, v.n - 1));
         v        = model(v);
         stub_lat = int'($urandom_range(1, 4));
         run_vec(v);
      end

`ifdef CRC_SEQ_TIMEOUT_EN
      clear_metrics();
      stub_never = 1'b1;
      send_word(8'h5A, 1'b1, ok);
      wait_result(got, rise);
      check("timeout_err", bus.RES_ERR, 32'd1);
      check("timeout_crc", bus.RES_CRC, 32'd0);
      check("timeout_latency", rise - last_active_cyc, 33);
      bus.RES_READY = 1'b1;
      @(negedge clk);
      bus.RES_READY = 1'b0;
      stub_never    = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
